// File: rtl/pong_engine.sv
// Single-player Pong: frame-rate game state and registered per-pixel RGB.
// Optional hit-count bar enabled by defining PONG_SCORE_BAR_EN.
module pong_engine #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_X     = 16,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_STEP  = 4,
  parameter int BALL_STEP    = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hsp,
  input  logic [9:0] vsp,
  input  logic       disparea,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [3:0] hits,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    SERVE = 2'b00,
    PLAY  = 2'b01,
    MISS  = 2'b10
  } state_t;

  localparam logic [9:0] X_C    = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] Y_C    = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0] P_C    = 10'((V_ACTIVE - PADDLE_H) / 2);
  localparam logic [9:0] P_MAX  = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] P_STEP = 10'(PADDLE_STEP);
  localparam logic [9:0] V_END  = 10'(V_ACTIVE);
  localparam logic [9:0] PAD_L  = 10'(PADDLE_X);
  localparam logic [9:0] PAD_R  = 10'(PADDLE_X + PADDLE_W - 1);
  localparam logic [9:0] NET_L  = 10'(H_ACTIVE / 2 - 1);
  localparam logic [9:0] NET_R  = 10'(H_ACTIVE / 2);

  localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] X_HIT  = 11'(PADDLE_X + PADDLE_W);
  localparam logic signed [10:0] B_STEP = 11'(BALL_STEP);

  localparam logic [10:0] B_EXT = 11'(BALL_SIZE - 1);
  localparam logic [10:0] P_EXT = 11'(PADDLE_H - 1);

  localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);
  localparam logic [5:0] MISS_LAST  = 6'(MISS_FRAMES - 1);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [9:0]  bx_q, bx_d;
  logic [9:0]  by_q, by_d;
  logic        dx_q, dx_d;
  logic        dy_q, dy_d;
  logic [9:0]  py_q, py_d;
  logic [3:0]  hits_q, hits_d;
  logic [2:0]  rgb_q, rgb_d;

  logic               frame_tick;
  logic signed [10:0] nx, ny;
  logic [9:0]         by_r;
  logic               dy_r;
  logic [10:0]        b_top, b_bot;
  logic [10:0]        p_top, p_bot;
  logic               overlap;

  logic [10:0] h_ext, v_ext;
  logic        in_ball, in_pad, in_net;
`ifdef PONG_SCORE_BAR_EN
  logic        in_bar;
`endif

  assign frame_tick = (hsp == 10'd0) && (vsp == V_END);

  // paddle motion from the held buttons, clamped to the screen
  always_comb begin
    py_d = py_q;
    if (frame_tick) begin
      if (btn_up && !btn_down) begin
        py_d = (py_q < P_STEP) ? 10'd0 : py_q - P_STEP;
      end else if (btn_down && !btn_up) begin
        py_d = (py_q > P_MAX - P_STEP) ? P_MAX : py_q + P_STEP;
      end
    end
  end

  // candidate ball step, vertical wall resolution and paddle overlap
  always_comb begin
    nx = dx_q ? ($signed({1'b0, bx_q}) + B_STEP)
              : ($signed({1'b0, bx_q}) - B_STEP);
    ny = dy_q ? ($signed({1'b0, by_q}) + B_STEP)
              : ($signed({1'b0, by_q}) - B_STEP);
    by_r = ny[9:0];
    dy_r = dy_q;
    if (ny < 11'sd0) begin
      by_r = 10'd0;
      dy_r = 1'b1;
    end else if (ny > Y_MAX) begin
      by_r = Y_MAX[9:0];
      dy_r = 1'b0;
    end
    b_top   = {1'b0, by_r};
    b_bot   = b_top + B_EXT;
    p_top   = {1'b0, py_q};
    p_bot   = p_top + P_EXT;
    overlap = (b_top <= p_bot) && (b_bot >= p_top);
  end

  // serve / play / miss sequencing and ball update, once per frame
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bx_d    = bx_q;
    by_d    = by_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    hits_d  = hits_q;
    if (frame_tick) begin
      unique case (state_q)
        SERVE: begin
          bx_d = X_C;
          by_d = Y_C;
          dx_d = 1'b1;
          dy_d = 1'b1;
          if (cnt_q == SERVE_LAST) begin
            state_d = PLAY;
            cnt_d   = 6'd0;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        PLAY: begin
          by_d = by_r;
          dy_d = dy_r;
          if (nx > X_MAX) begin
            bx_d = X_MAX[9:0];
            dx_d = 1'b0;
          end else if (!dx_q && (nx <= X_HIT) && overlap) begin
            bx_d   = X_HIT[9:0];
            dx_d   = 1'b1;
            hits_d = hits_q + 4'd1;
          end else if (nx <= 11'sd0) begin
            bx_d    = 10'd0;
            state_d = MISS;
            cnt_d   = 6'd0;
          end else begin
            bx_d = nx[9:0];
          end
        end
        MISS: begin
          if (cnt_q == MISS_LAST) begin
            state_d = SERVE;
            cnt_d   = 6'd0;
            bx_d    = X_C;
            by_d    = Y_C;
            dx_d    = 1'b1;
            dy_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        default: begin
          state_d = SERVE;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  // game state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SERVE;
      cnt_q   <= 6'd0;
      bx_q    <= X_C;
      by_q    <= Y_C;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      py_q    <= P_C;
      hits_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      py_q    <= py_d;
      hits_q  <= hits_d;
    end
  end

  // object coverage of the current pixel and colour priority
  always_comb begin
    h_ext   = {1'b0, hsp};
    v_ext   = {1'b0, vsp};
    in_ball = (hsp >= bx_q) && (h_ext <= {1'b0, bx_q} + B_EXT)
           && (vsp >= by_q) && (v_ext <= {1'b0, by_q} + B_EXT);
    in_pad  = (hsp >= PAD_L) && (hsp <= PAD_R)
           && (vsp >= py_q) && (v_ext <= {1'b0, py_q} + P_EXT);
    in_net  = (hsp >= NET_L) && (hsp <= NET_R) && !vsp[3];
`ifdef PONG_SCORE_BAR_EN
    in_bar  = (vsp >= 10'd4) && (vsp <= 10'd11) && (hsp >= 10'd4)
           && (h_ext < 11'd4 + {3'b000, hits_q, 4'b0000});
`endif
    rgb_d = 3'b000;
    if (!disparea) begin
      rgb_d = 3'b000;
    end else if (in_ball) begin
      rgb_d = (state_q == MISS) ? 3'b100 : 3'b111;
`ifdef PONG_SCORE_BAR_EN
    end else if (in_bar) begin
      rgb_d = 3'b110;
`endif
    end else if (in_pad) begin
      rgb_d = 3'b010;
    end else if (in_net) begin
      rgb_d = 3'b001;
    end
  end

  // pixel output register, one clock behind the position inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q <= 3'b000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign red     = rgb_q[2];
  assign green   = rgb_q[1];
  assign blue    = rgb_q[0];
  assign hits    = hits_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: pixel vector table,
// directed game sequences and random buttons against a frame model.
module tb_pong_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hsp, vsp;
  logic       disparea;
  logic       btn_up, btn_down;
  logic       red, green, blue;
  logic [3:0] hits;
  logic [1:0] state_o;

  int checks = 0;
  int failures = 0;

  pong_engine dut (
    .clk(clk), .rst_n(rst_n),
    .hsp(hsp), .vsp(vsp), .disparea(disparea),
    .btn_up(btn_up), .btn_down(btn_down),
    .red(red), .green(green), .blue(blue),
    .hits(hits), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // frame-level model: positions, velocity signs, state, counters
  int mx, my, mdx, mdy, mpy, mst, mcnt, mhits;

  task automatic model_reset();
    mx = 316; my = 236; mdx = 1; mdy = 1;
    mpy = 208; mst = 0; mcnt = 0; mhits = 0;
  endtask

  task automatic model_step(input bit up, input bit dn);
    int pold, tx, ty;
    bit ov;
    pold = mpy;
    if (up && !dn) mpy = (mpy - 4 < 0) ? 0 : mpy - 4;
    if (dn && !up) mpy = (mpy + 4 > 416) ? 416 : mpy + 4;
    if (mst == 0) begin
      mx = 316; my = 236; mdx = 1; mdy = 1;
      if (mcnt == 59) begin mst = 1; mcnt = 0; end
      else mcnt++;
    end else if (mst == 1) begin
      tx = mx + 2 * mdx;
      ty = my + 2 * mdy;
      if (ty < 0) begin my = 0; mdy = 1; end
      else if (ty > 472) begin my = 472; mdy = -1; end
      else my = ty;
      ov = (my <= pold + 63) && (my + 7 >= pold);
      if (tx > 632) begin mx = 632; mdx = -1; end
      else if (mdx < 0 && tx <= 24 && ov) begin
        mx = 24; mdx = 1; mhits = (mhits + 1) % 16;
      end else if (tx <= 0) begin
        mx = 0; mst = 2; mcnt = 0;
      end else mx = tx;
    end else begin
      if (mcnt == 29) begin
        mst = 0; mcnt = 0;
        mx = 316; my = 236; mdx = 1; mdy = 1;
      end else mcnt++;
    end
  endtask

  function automatic int exp_pix(input int x, input int y);
    if (x >= mx && x <= mx + 7 && y >= my && y <= my + 7)
      return (mst == 2) ? 4 : 7;
    if (x >= 16 && x <= 23 && y >= mpy && y <= mpy + 63) return 2;
    if ((x == 319 || x == 320) && (y % 16) < 8) return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic pix(input int x, input int y, input bit d,
                     output logic [2:0] c);
    @(negedge clk);
    hsp = 10'(x); vsp = 10'(y); disparea = d;
    @(negedge clk);
    c = {red, green, blue};
    hsp = 10'd1; vsp = 10'd480; disparea = 1'b0;
  endtask

  task automatic check_ball(input int x, input int y, input logic [2:0] col);
    logic [2:0] c0, c1, c2, c3;
    logic [3:0] got;
    pix(x, y, 1'b1, c0);
    pix(x + 7, y + 7, 1'b1, c1);
    pix(x + 8, y, 1'b1, c2);
    pix(x + 7, y + 8, 1'b1, c3);
    got = {c0 == col, c1 == col, c2 != col, c3 != col};
    checks++;
    if (got != 4'b1111) begin
      failures++;
      $display("FAIL ball_at(%0d,%0d) col %b: probes %b %b %b %b required pattern 1111 got %b",
               x, y, col, c0, c1, c2, c3, got);
    end
  endtask

  task automatic check_paddle(input int y);
    logic [2:0] c0, c1, c2, c3;
    logic [3:0] got, want;
    pix(16, y, 1'b1, c0);
    pix(23, y + 63, 1'b1, c1);
    pix(16, y + 64, 1'b1, c2);
    pix(16, (y > 0) ? y - 1 : y, 1'b1, c3);
    got  = {c0 == 3'b010, c1 == 3'b010, c2 == 3'b010, c3 == 3'b010};
    want = {1'b1, 1'b1, 1'b0, (y == 0)};
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL paddle_at(%0d): probe pattern %b required %b", y, got, want);
    end
  endtask

  task automatic tick(input bit up, input bit dn);
    @(negedge clk);
    btn_up = up; btn_down = dn; hsp = 10'd0; vsp = 10'd480;
    @(negedge clk);
    hsp = 10'd1; btn_up = 1'b0; btn_down = 1'b0;
    model_step(up, dn);
    chk("state", int'(state_o), mst);
    chk("hits", int'(hits), mhits);
  endtask

  typedef struct {
    int         h;
    int         v;
    bit         d;
    logic [2:0] e;
  } vec_t;

  vec_t vt[15];

  initial begin
    #4ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] c;
    int n, total, prev;
    bit up, dn;
    logic [31:0] r;

    vt[0]  = '{320, 0,   1'b1, 3'b001};
    vt[1]  = '{319, 0,   1'b1, 3'b001};
    vt[2]  = '{321, 0,   1'b1, 3'b000};
    vt[3]  = '{318, 0,   1'b1, 3'b000};
    vt[4]  = '{320, 8,   1'b1, 3'b000};
    vt[5]  = '{320, 0,   1'b0, 3'b000};
    vt[6]  = '{320, 240, 1'b1, 3'b111};
    vt[7]  = '{316, 236, 1'b1, 3'b111};
    vt[8]  = '{315, 236, 1'b1, 3'b000};
    vt[9]  = '{16,  208, 1'b1, 3'b010};
    vt[10] = '{23,  271, 1'b1, 3'b010};
    vt[11] = '{24,  240, 1'b1, 3'b000};
    vt[12] = '{16,  272, 1'b1, 3'b000};
    vt[13] = '{100, 100, 1'b0, 3'b000};
    vt[14] = '{639, 479, 1'b1, 3'b000};

    rst_n = 1'b0; hsp = 10'd1; vsp = 10'd480; disparea = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rgb", int'({red, green, blue}), 0);
    chk("rst_hits", int'(hits), 0);
    chk("rst_state", int'(state_o), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      pix(vt[i].h, vt[i].v, vt[i].d, c);
      checks++;
      if (c !== vt[i].e) begin
        failures++;
        $display("FAIL pixel_vec[%0d] (%0d,%0d,%0b): rgb %b required %b",
                 i, vt[i].h, vt[i].v, vt[i].d, c, vt[i].e);
      end
    end
    check_ball(316, 236, 3'b111);
    check_paddle(208);

    repeat (59) tick(1'b0, 1'b0);
    chk("serve_59", int'(state_o), 0);
    check_ball(316, 236, 3'b111);
    tick(1'b0, 1'b0);
    chk("play_60", int'(state_o), 1);
    check_ball(316, 236, 3'b111);
    tick(1'b0, 1'b0);
    check_ball(318, 238, 3'b111);

    repeat (70) tick(1'b1, 1'b0);
    check_paddle(0);
    repeat (10) tick(1'b0, 1'b1);
    check_paddle(40);
    repeat (5) tick(1'b1, 1'b1);
    check_paddle(40);

    n = 0;
    while (mdx == 1 && n < 400) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("wall_reached", int'(n < 400), 1);
    check_ball(632, my, 3'b111);
    tick(1'b0, 1'b0);
    check_ball(630, my, 3'b111);
    tick(1'b0, 1'b0);
    check_ball(628, my, 3'b111);
    chk("hits_after_wall", int'(hits), 0);

    total = 0; n = 0;
    while (total < 16 && n < 12000) begin
      up = (mpy + 32 > my + 6);
      dn = (mpy + 32 < my + 2);
      prev = mhits;
      tick(up, dn);
      if (mhits != prev) begin
        total++;
        if (total == 1) begin
          check_ball(24, my, 3'b111);
          chk("first_hit", int'(hits), 1);
        end
      end
      if (n % 16 == 0) check_ball(mx, my, (mst == 2) ? 3'b100 : 3'b111);
      n++;
    end
    chk("hit_count_16", total, 16);
    chk("hits_wrapped", int'(hits), 0);

    n = 0;
    while (mst != 2 && n < 5000) begin
      if (my + 4 < 240) tick(1'b0, 1'b1);
      else tick(1'b1, 1'b0);
      n++;
    end
    chk("miss_reached", int'(state_o), 2);
    check_ball(0, my, 3'b100);
    repeat (14) tick(1'b0, 1'b0);
    check_ball(0, my, 3'b100);
    repeat (15) tick(1'b0, 1'b0);
    chk("miss_29", int'(state_o), 2);
    check_ball(0, my, 3'b100);
    tick(1'b0, 1'b0);
    chk("serve_after_miss", int'(state_o), 0);
    check_ball(316, 236, 3'b111);

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      tick(r[0], r[1]);
      if (i % 8 == 0) check_ball(mx, my, (mst == 2) ? 3'b100 : 3'b111);
    end
    check_paddle(mpy);

    @(negedge clk);
    hsp = 10'd320; vsp = 10'd0; disparea = 1'b1;
    @(negedge clk);
    chk("pre_reset_pix", int'({red, green, blue}), exp_pix(320, 0));
    #2 rst_n = 1'b0;
    #1 chk("async_reset_rgb", int'({red, green, blue}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    chk("resume_pix", int'({red, green, blue}), 1);
    chk("reset_hits", int'(hits), 0);
    chk("reset_state", int'(state_o), 0);
    hsp = 10'd1; vsp = 10'd480; disparea = 1'b0;
    check_ball(316, 236, 3'b111);
    check_paddle(208);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
